// File: rtl/muldiv_if.sv
// Handshake bundle between the main control FSM / MULT-DIV units and the
// muldiv_sequencer.
//   master : request side (main FSM) plus the units' completion flags
//   slave  : the sequencer itself
// Signals:
//   req, req_div                 request and op type (0=MULT, 1=DIV)
//   mult_fim, div_fim, div_zero  unit completion / divide-by-zero flags
//   mult_start, div_start        unit start pulses
//   hi_sel, lo_sel               HI/LO mux selects (0=mult, 1=div)
//   hi_write, lo_write           HI/LO write enables
//   busy, done, dz_exc, timeout  status back to the main FSM
interface muldiv_if;
    logic req;
    logic req_div;
    logic mult_fim;
    logic div_fim;
    logic div_zero;
    logic mult_start;
    logic div_start;
    logic hi_sel;
    logic lo_sel;
    logic hi_write;
    logic lo_write;
    logic busy;
    logic done;
    logic dz_exc;
    logic timeout;

    modport master (
        output req, req_div, mult_fim, div_fim, div_zero,
        input  mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
               busy, done, dz_exc, timeout
    );

    modport slave (
        input  req, req_div, mult_fim, div_fim, div_zero,
        output mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
               busy, done, dz_exc, timeout
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divisor pair for the multicycle CPU.
// Accepts one MULT/DIV request from the main FSM, pulses the matching start
// line, waits for that unit's completion flag, then writes HI/LO and reports
// done, or reports divide-by-zero without writing.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-high
//   bus    muldiv_if.slave (request, unit flags, start/select/write/status)
// Optional feature: define MULDIV_TIMEOUT_EN to add a WAIT-state watchdog
// that pulses timeout and returns to IDLE after TIMEOUT_CYCLES WAIT cycles.
// Without it timeout is tied low and WAIT holds indefinitely.
// Every output is a flop loaded from the next-state decode, so there is no
// combinational path from any input to any output.
module muldiv_sequencer #(
    parameter int unsigned START_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input logic     clock,
    input logic     reset,
    muldiv_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] EXC   = 3'd5;

    // Counter never needs to exceed the larger of the two phase lengths.
    localparam int unsigned CntMax =
        (START_CYCLES > TIMEOUT_CYCLES) ? START_CYCLES : TIMEOUT_CYCLES;
    localparam logic [CNT_W-1:0] cntLimit  = CNT_W'(CntMax - 1);
    localparam logic [CNT_W-1:0] startLast = CNT_W'(START_CYCLES - 1);
`ifdef MULDIV_TIMEOUT_EN
    localparam logic [CNT_W-1:0] timeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    logic [2:0]       state;
    logic [2:0]       nextState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nextCnt;
    logic [CNT_W-1:0] incCnt;
    logic             opDiv;
    logic             nextOpDiv;
    logic             selFim;

    logic multStartQ;
    logic divStartQ;
    logic selQ;
    logic writeQ;
    logic busyQ;
    logic doneQ;
    logic dzExcQ;
`ifdef MULDIV_TIMEOUT_EN
    logic nextTimeout;
    logic timeoutQ;
`endif

    // Next-state, counter and op-type decode.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        nextOpDiv = opDiv;
`ifdef MULDIV_TIMEOUT_EN
        nextTimeout = 1'b0;
`endif
        incCnt = (cnt == cntLimit) ? cnt : cnt + CNT_W'(1);
        // Only the unit that was started may complete the op.
        selFim = opDiv ? bus.div_fim : bus.mult_fim;

        case (state)
            IDLE: begin
                if (bus.req) begin
                    nextState = START;
                    nextOpDiv = bus.req_div;
                    nextCnt   = '0;
                end
            end
            START: begin
                if (cnt == startLast) begin
                    nextState = WAIT;
                    nextCnt   = '0;
                end else begin
                    nextCnt = incCnt;
                end
            end
            WAIT: begin
                // Divide-by-zero outranks a simultaneous div_fim.
                if (opDiv && bus.div_zero) begin
                    nextState = EXC;
                end else if (selFim) begin
                    nextState = WRITE;
                end
`ifdef MULDIV_TIMEOUT_EN
                // Completion in the final watchdog cycle still wins.
                else if (cnt == timeoutLast) begin
                    nextState   = IDLE;
                    nextTimeout = 1'b1;
                end else begin
                    nextCnt = incCnt;
                end
`endif
            end
            WRITE:   nextState = DONE;
            DONE:    nextState = IDLE;
            EXC:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            opDiv      <= 1'b0;
            multStartQ <= 1'b0;
            divStartQ  <= 1'b0;
            selQ       <= 1'b0;
            writeQ     <= 1'b0;
            busyQ      <= 1'b0;
            doneQ      <= 1'b0;
            dzExcQ     <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            timeoutQ   <= 1'b0;
`endif
        end else begin
            state      <= nextState;
            cnt        <= nextCnt;
            opDiv      <= nextOpDiv;
            multStartQ <= (nextState == START) && !nextOpDiv;
            divStartQ  <= (nextState == START) && nextOpDiv;
            selQ       <= (nextState != IDLE) && nextOpDiv;
            writeQ     <= (nextState == WRITE);
            busyQ      <= (nextState != IDLE);
            doneQ      <= (nextState == DONE);
            dzExcQ     <= (nextState == EXC);
`ifdef MULDIV_TIMEOUT_EN
            timeoutQ   <= nextTimeout;
`endif
        end
    end

    assign bus.mult_start = multStartQ;
    assign bus.div_start  = divStartQ;
    assign bus.hi_sel     = selQ;
    assign bus.lo_sel     = selQ;
    assign bus.hi_write   = writeQ;
    assign bus.lo_write   = writeQ;
    assign bus.busy       = busyQ;
    assign bus.done       = doneQ;
    assign bus.dz_exc     = dzExcQ;
`ifdef MULDIV_TIMEOUT_EN
    assign bus.timeout    = timeoutQ;
`else
    assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer. Expected outputs come from a
// per-operation timeline model: cycle k relative to the accepted request.
// Output vector bit order:
//   {mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
//    busy, done, dz_exc, timeout}
module tb_muldiv_sequencer;

    localparam int unsigned S  = 1;   // start pulse width
    localparam int unsigned T  = 8;   // watchdog limit
    localparam int unsigned CW = 7;

    localparam int K_OK = 0;
    localparam int K_DZ = 1;
    localparam int K_TO = 2;

    logic clock;
    logic reset;
    logic [9:0] obs;
    int vectors = 0;
    int miscompares = 0;

    muldiv_if bus ();

    muldiv_sequencer #(
        .START_CYCLES  (S),
        .TIMEOUT_CYCLES(T),
        .CNT_W         (CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign obs = {bus.mult_start, bus.div_start, bus.hi_sel, bus.lo_sel,
                  bus.hi_write, bus.lo_write, bus.busy, bus.done,
                  bus.dz_exc, bus.timeout};

    // Expected outputs in cycle k for a request accepted in cycle 0 whose
    // terminating event (fim / div_zero / last watchdog cycle) is in cycle e.
    function automatic logic [9:0] model(int k, bit isDiv, int e, int kind);
        logic [9:0] r;
        bit act;
        r = '0;
        act = 1'b0;
        if (k >= 1 && k <= int'(S)) begin
            r[9] = !isDiv;
            r[8] = isDiv;
            act  = 1'b1;
        end else if (k > int'(S) && k <= e) begin
            act = 1'b1;
        end else if (k == e + 1) begin
            if (kind == K_OK) begin
                r[5] = 1'b1;
                r[4] = 1'b1;
                act  = 1'b1;
            end else if (kind == K_DZ) begin
                r[1] = 1'b1;
                act  = 1'b1;
            end else begin
                r[0] = 1'b1;
            end
        end else if (k == e + 2 && kind == K_OK) begin
            r[2] = 1'b1;
            act  = 1'b1;
        end
        if (act) begin
            r[3] = 1'b1;
            r[7] = isDiv;
            r[6] = isDiv;
        end
        return r;
    endfunction

    task automatic quiet();
        bus.req      = 1'b0;
        bus.req_div  = 1'b0;
        bus.mult_fim = 1'b0;
        bus.div_fim  = 1'b0;
        bus.div_zero = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        quiet();
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++;
        if (obs !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected %b", obs, 10'b0);
        end
        bus.req = 1'b1;
        @(negedge clock);
        vectors++;
        if (obs !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_blocks_req: got %b expected %b", obs, 10'b0);
        end
        bus.req = 1'b0;
        reset   = 1'b0;
        @(negedge clock);
        vectors++;
        if (obs !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %b expected %b", obs, 10'b0);
        end
    endtask

    // MULT with mult_fim in cycle 34.
    task automatic test_mult();
        logic [9:0] exp;
        for (int k = 0; k <= 38; k++) begin
            @(negedge clock);
            exp = model(k, 1'b0, 34, K_OK);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL mult cycle %0d: got %b expected %b", k, obs, exp);
            end
            quiet();
            bus.req      = (k == 0);
            bus.mult_fim = (k == 34);
            bus.div_fim  = 1'($urandom);
            bus.div_zero = 1'($urandom);
        end
    endtask

    // DIV with div_zero in the 3rd WAIT cycle, colliding with div_fim.
    task automatic test_div_zero();
        logic [9:0] exp;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clock);
            exp = model(k, 1'b1, 4, K_DZ);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL div_zero cycle %0d: got %b expected %b", k, obs, exp);
            end
            quiet();
            bus.req      = (k == 0);
            bus.req_div  = 1'b1;
            bus.div_zero = (k == 4);
            bus.div_fim  = (k == 4);
        end
    endtask

    // DIV with stray mult_fim in WAIT, div_fim 10 cycles later.
    task automatic test_stray();
        logic [9:0] exp;
        for (int k = 0; k <= 18; k++) begin
            @(negedge clock);
            exp = model(k, 1'b1, 13, K_OK);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL stray_fim cycle %0d: got %b expected %b", k, obs, exp);
            end
            quiet();
            bus.req      = (k == 0);
            bus.req_div  = 1'b1;
            bus.mult_fim = (k == 3);
            bus.div_fim  = (k == 13);
        end
    endtask

    // req held high for 50 cycles; each op completes 20 cycles after its
    // accept, so accepts land at 0, 23 and 46 only.
    task automatic test_back_to_back();
        logic [9:0] exp;
        int a;
        for (int k = 0; k <= 75; k++) begin
            a = (k / 23) * 23;
            if (a > 46) a = 46;
            @(negedge clock);
            exp = model(k - a, 1'b0, 20, K_OK);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", k, obs, exp);
            end
            quiet();
            bus.req      = (k < 50);
            bus.mult_fim = ((k - a) == 20);
        end
    endtask

    // Reset pulse mid-WAIT aborts the op; later fim ignored; fresh op runs.
    task automatic test_reset_mid();
        logic [9:0] exp;
        for (int k = 0; k <= 23; k++) begin
            @(negedge clock);
            if (k <= 5)      exp = model(k, 1'b0, 1000, K_OK);
            else if (k < 13) exp = '0;
            else             exp = model(k - 13, 1'b0, 6, K_OK);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_mid cycle %0d: got %b expected %b", k, obs, exp);
            end
            quiet();
            reset        = (k == 5);
            bus.req      = (k == 0) || (k == 13);
            bus.mult_fim = (k == 8) || (k == 19);
        end
        reset = 1'b0;
    endtask

    // Random ops with noise on every input the sequencer must ignore.
    task automatic test_random();
        logic [9:0] exp;
        bit isDiv;
        bit pre;
        int e;
        int kind;
        for (int op = 0; op < 25; op++) begin
            isDiv = 1'($urandom);
            e     = int'(S) + int'($urandom_range(1, 40));
            kind  = (isDiv && ($urandom_range(0, 2) == 0)) ? K_DZ : K_OK;
            for (int k = 0; k <= e + 3; k++) begin
                @(negedge clock);
                exp = model(k, isDiv, e, kind);
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL random op %0d cycle %0d: got %b expected %b",
                             op, k, obs, exp);
                end
                pre = (k > int'(S)) && (k < e);
                bus.req     = (k == 0);
                bus.req_div = (k == 0) ? isDiv : 1'($urandom);
                if (!isDiv) begin
                    bus.mult_fim = (k == e) ? 1'b1 : (pre ? 1'b0 : 1'($urandom));
                    bus.div_fim  = 1'($urandom);
                    bus.div_zero = 1'($urandom);
                end else begin
                    bus.mult_fim = 1'($urandom);
                    if (k == e) begin
                        bus.div_zero = (kind == K_DZ);
                        bus.div_fim  = (kind == K_DZ) ? 1'($urandom) : 1'b1;
                    end else if (pre) begin
                        bus.div_zero = 1'b0;
                        bus.div_fim  = 1'b0;
                    end else begin
                        bus.div_zero = 1'($urandom);
                        bus.div_fim  = 1'($urandom);
                    end
                end
            end
        end
        quiet();
    endtask

`ifdef MULDIV_TIMEOUT_EN
    // No fim: timeout after T WAIT cycles; then fim exactly in the last one.
    task automatic test_timeout();
        logic [9:0] exp;
        int e;
        e = int'(S + T);
        for (int k = 0; k <= e + 3; k++) begin
            @(negedge clock);
            exp = model(k, 1'b1, e, K_TO);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL timeout cycle %0d: got %b expected %b", k, obs, exp);
            end
            quiet();
            bus.req      = (k == 0);
            bus.req_div  = 1'b1;
            bus.mult_fim = 1'($urandom);
        end
        for (int k = 0; k <= e + 3; k++) begin
            @(negedge clock);
            exp = model(k, 1'b1, e, K_OK);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL timeout_fim_wins cycle %0d: got %b expected %b", k, obs, exp);
            end
            quiet();
            bus.req     = (k == 0);
            bus.req_div = 1'b1;
            bus.div_fim = (k == e);
        end
    endtask
`else
    // No watchdog: WAIT holds for 100 cycles with timeout low.
    task automatic test_hold();
        logic [9:0] exp;
        int e;
        e = int'(S) + 100;
        for (int k = 0; k <= e + 3; k++) begin
            @(negedge clock);
            exp = model(k, 1'b1, e, K_OK);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL wait_hold cycle %0d: got %b expected %b", k, obs, exp);
            end
            quiet();
            bus.req      = (k == 0);
            bus.req_div  = 1'b1;
            bus.div_fim  = (k == e);
            bus.mult_fim = 1'($urandom);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        quiet();
        test_reset();
        test_mult();
        test_div_zero();
        test_stray();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef MULDIV_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
